vram_write_arbiter: RTL

Shares the single-port 12-bit pixel block memory between the VGA scan-out reader and a game-logic writer that repaints sudoku cells and digits. Scan-out owns the memory port during active video. Writer requests are buffered in a small FIFO and committed only during horizontal or vertical blanking. The block sits between the frame-address generator / VGA controller and the pixel block memory, and runs on the 25 MHz pixel clock.

---
 rtl/vram_write_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/vram_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vram_write_arbiter
// Purpose  : Shares the single-port pixel memory between VGA scan-out and a
//            FIFO-buffered game-logic writer that drains only during blanking.
// Revision : 1.0 - initial release
// ============================================================================
module vram_write_arbiter #(
    parameter int ADDR_W     = 17,
    parameter int DATA_W     = 12,
    parameter int FIFO_DEPTH = 8,
    parameter int GUARD      = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [9:0]                  h_cnt,
    input  logic [9:0]                  v_cnt,
    input  logic [ADDR_W-1:0]           rd_addr,
    input  logic                        wr_valid,
    input  logic [ADDR_W-1:0]           wr_addr,
    input  logic [DATA_W-1:0]           wr_data,
    output logic                        wr_ready,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_din,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [15:0]                 wr_count
);

    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int c_lvl_w = c_ptr_w + 1;

    localparam logic [c_lvl_w-1:0] c_full    = c_lvl_w'(FIFO_DEPTH);
    localparam logic [c_lvl_w-1:0] c_lvl_one = c_lvl_w'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);
    localparam logic [9:0]         c_h_blank = 10'd640;
    localparam logic [9:0]         c_h_guard = 10'(800 - GUARD);
    localparam logic [9:0]         c_v_blank = 10'd480;
    localparam logic [9:0]         c_v_last  = 10'd524;

    typedef enum logic [0:0] {
        READ  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [ADDR_W-1:0]     r_fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0]     r_fifo_data [FIFO_DEPTH];
    logic [c_ptr_w-1:0]    r_wr_ptr;
    logic [c_ptr_w-1:0]    r_rd_ptr;
    logic [c_lvl_w-1:0]    r_level;
    logic [15:0]           r_count;

    logic                  w_write_ok;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_not_empty;

    // The last line of the frame loses its tail so the port is free again
    // well before line 0 starts fetching pixels.
    assign w_write_ok = ((h_cnt >= c_h_blank && h_cnt < c_h_guard) || v_cnt >= c_v_blank)
                        && !(v_cnt == c_v_last && h_cnt >= c_h_guard);

    assign w_not_empty = (r_level != '0);
    assign wr_ready    = (r_level < c_full);
    assign w_push      = wr_valid && wr_ready;
    // Gating on write_ok keeps a stale WRITE state from ever touching active video.
    assign w_pop       = (r_state == WRITE) && w_write_ok && w_not_empty;

    assign fifo_level  = r_level;
    assign wr_count    = r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= READ;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        mem_we      = w_pop;
        mem_addr    = rd_addr;
        mem_din     = '0;

        if (w_pop) begin
            mem_addr = r_fifo_addr[r_rd_ptr];
            mem_din  = r_fifo_data[r_rd_ptr];
        end

        case (r_state)
            READ: begin
                if (w_write_ok && w_not_empty) begin
                    w_state_nxt = WRITE;
                end
            end
            WRITE: begin
                if (!w_write_ok || (w_pop && !w_push && r_level == c_lvl_one)) begin
                    w_state_nxt = READ;
                end
            end
            default: w_state_nxt = READ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
                r_count  <= r_count + 16'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_lvl_one;
                2'b01:   r_level <= r_level - c_lvl_one;
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage needs no reset: the level register alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= wr_addr;
            r_fifo_data[r_wr_ptr] <= wr_data;
        end
    end

endmodule
`default_nettype wire
